// File: rtl/pulse_train_gen_if.sv
// Control/stream bundle between the lab test controller and pulse_train_gen.
// The controller drives start/count/gap. The generator drives out/busy/done/mod3.
interface pulse_train_gen_if #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
);
   logic             start;
   logic [CNT_W-1:0] count;
   logic [GAP_W-1:0] gap;
   logic             out;
   logic             busy;
   logic             done;
   logic             mod3;

   modport master (
      output start,
      output count,
      output gap,
      input  out,
      input  busy,
      input  done,
      input  mod3
   );

   modport slave (
      input  start,
      input  count,
      input  gap,
      output out,
      output busy,
      output done,
      output mod3
   );
endinterface

// File: rtl/pulse_train_gen.sv
// Serial pulse-train transmitter.
// Emits N single-cycle high pulses, each followed by a programmable low gap.
// It also produces a registered mod-3 reference for the pulse-counting detectors.
// Every output is a register decoded from state and counters, so the output
// timeline trails the state register by one cycle.
module pulse_train_gen #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   pulse_train_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_nx;

   logic [CNT_W-1:0] cnt_lat;
   logic [GAP_W-1:0] gap_lat;
   logic [CNT_W-1:0] sent;
   logic [GAP_W-1:0] gap_cnt;
   logic [1:0]       residue;

   logic             out_q;
   logic             busy_q;
   logic             done_q;
   logic             mod3_q;

   logic             accept;
   logic             last_pulse;

   // A zero gap request still leaves one low cycle, so pulses never merge.
   function automatic logic [GAP_W-1:0] gap_floor1(input logic [GAP_W-1:0] g);
      return (g == '0) ? GAP_W'(1) : g;
   endfunction

   // Residue of pulses sent, modulo 3, with an explicit wrap from 2 to 0.
   function automatic logic [1:0] residue_step(input logic [1:0] r);
      return (r == 2'd2) ? 2'd0 : r + 2'd1;
   endfunction

   // Comparing against count-1 checks completion before the increment,
   // so sent never has to hold the value count itself.
   assign accept     = (state_q == ST_IDLE) && bus.start;
   assign last_pulse = (sent == cnt_lat - CNT_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state decode. start is only looked at in IDLE.
   always_comb begin
      state_nx = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.count != '0) begin
                  state_nx = ST_PULSE;
               end else begin
                  state_nx = ST_DONE;
               end
            end
         end
         ST_PULSE: begin
            if (last_pulse) begin
               state_nx = ST_DONE;
            end else begin
               state_nx = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt <= GAP_W'(1)) begin
               state_nx = ST_PULSE;
            end
         end
         ST_DONE: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Request latch. count/gap are captured once per train and then frozen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_lat <= '0;
         gap_lat <= '0;
      end else if (accept) begin
         cnt_lat <= bus.count;
         gap_lat <= bus.gap;
      end
   end

   // Pulse bookkeeping: the sent counter and the mod-3 residue.
   // Both advance on the edge that ends a pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sent    <= '0;
         residue <= 2'd0;
      end else if (accept) begin
         sent    <= '0;
         residue <= 2'd0;
      end else if (state_q == ST_PULSE) begin
         sent    <= sent + CNT_W'(1);
         residue <= residue_step(residue);
      end
   end

   // Gap countdown. It is loaded as a pulse ends and runs down while in GAP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gap_cnt <= '0;
      end else if ((state_q == ST_PULSE) && !last_pulse) begin
         gap_cnt <= gap_floor1(gap_lat);
      end else if ((state_q == ST_GAP) && (gap_cnt != '0)) begin
         gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   // Registered Moore outputs. These are decoded from the current state and
   // residue only. Reset clears them asynchronously, which aborts a train at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         mod3_q <= 1'b1;
      end else begin
         out_q  <= (state_q == ST_PULSE);
         busy_q <= (state_q == ST_PULSE) || (state_q == ST_GAP);
         done_q <= (state_q == ST_DONE);
         mod3_q <= (residue == 2'd0);
      end
   end

   assign bus.out  = out_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.mod3 = mod3_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen.
// A reference model queues the expected per-cycle outputs when a train is
// started. Each cycle pops one entry and compares it at the falling edge.
module tb_pulse_train_gen;

   localparam int CNT_W = 8;
   localparam int GAP_W = 4;

   typedef struct {
      string    tag;
      logic [3:0] mask;   // [3]=out [2]=busy [1]=done [0]=mod3
      logic     o;
      logic     b;
      logic     d;
      logic     m;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];

   pulse_train_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

   pulse_train_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [3:0] mask,
                           input logic o, input logic b, input logic d, input logic m);
      exp_t e;
      e.tag  = tag;
      e.mask = mask;
      e.o    = o;
      e.b    = b;
      e.d    = d;
      e.m    = m;
      sb.push_back(e);
   endtask

   // Reference model. The cycles after the accepting edge are: pulses separated
   // by max(gap,1) low cycles, one done cycle, then one idle cycle. mod3 in a
   // cycle reflects the pulses emitted in the earlier cycles of the same train.
   task automatic push_train(input int c, input int g, input string tag);
      int gl;
      int pulses;
      int cyc;
      gl     = (g == 0) ? 1 : g;
      pulses = 0;
      cyc    = 0;
      for (int k = 0; k < c; k++) begin
         push_exp($sformatf("%s[%0d]", tag, cyc), 4'hF, 1'b1, 1'b1, 1'b0, (pulses % 3) == 0);
         pulses++;
         cyc++;
         if (k < c - 1) begin
            for (int j = 0; j < gl; j++) begin
               push_exp($sformatf("%s[%0d]", tag, cyc), 4'hF, 1'b0, 1'b1, 1'b0, (pulses % 3) == 0);
               cyc++;
            end
         end
      end
      push_exp($sformatf("%s[%0d]", tag, cyc), 4'hF, 1'b0, 1'b0, 1'b1, (pulses % 3) == 0);
      cyc++;
      push_exp($sformatf("%s[%0d]", tag, cyc), 4'hF, 1'b0, 1'b0, 1'b0, (pulses % 3) == 0);
   endtask

   task automatic start_train(input int c, input int g);
      @(negedge clk);
      bus.start = 1'b1;
      bus.count = CNT_W'(c);
      bus.gap   = GAP_W'(g);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Pops and compares one entry per cycle. From entry inj_at onward it
   // re-asserts start with new count/gap for two cycles.
   task automatic drain(input int inj_at, input int ic, input int ig);
      int idx;
      idx = 0;
      while (sb.size() > 0) begin
         exp_t e;
         @(negedge clk);
         e = sb.pop_front();
         if (e.mask[3]) check({e.tag, ".out"},  bus.out,  e.o);
         if (e.mask[2]) check({e.tag, ".busy"}, bus.busy, e.b);
         if (e.mask[1]) check({e.tag, ".done"}, bus.done, e.d);
         if (e.mask[0]) check({e.tag, ".mod3"}, bus.mod3, e.m);
         if (idx == inj_at) begin
            bus.start = 1'b1;
            bus.count = CNT_W'(ic);
            bus.gap   = GAP_W'(ig);
         end
         if (idx == inj_at + 2) begin
            bus.start = 1'b0;
         end
         idx++;
      end
   endtask

   initial begin
      int seen;
      int waited;
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.count = '0;
      bus.gap   = '0;

      // Reset with the clock running.
      repeat (3) @(negedge clk);
      check("rst.out",  bus.out,  1'b0);
      check("rst.busy", bus.busy, 1'b0);
      check("rst.done", bus.done, 1'b0);
      check("rst.mod3", bus.mod3, 1'b1);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_exp($sformatf("idle[%0d]", i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      drain(-10, 0, 0);

      // Basic train: count=3, gap=2.
      start_train(3, 2);
      push_train(3, 2, "c3g2");
      drain(-10, 0, 0);

      // count=0 completes immediately without a pulse.
      start_train(0, 3);
      push_train(0, 3, "c0");
      drain(-10, 0, 0);

      // gap=0 behaves as gap=1.
      start_train(4, 0);
      push_train(4, 0, "c4g0");
      drain(-10, 0, 0);

      // start/count/gap changed mid-train are ignored.
      start_train(5, 1);
      push_train(5, 1, "c5g1");
      drain(2, 2, 3);

      // Maximum count, small gap.
      start_train(255, 0);
      push_train(255, 0, "c255");
      drain(-10, 0, 0);

      // Asynchronous reset during the second pulse of a count=6 train.
      start_train(6, 2);
      seen   = 0;
      waited = 0;
      while (seen < 2 && waited < 30) begin
         if (bus.out === 1'b1) seen++;
         if (seen < 2) begin
            @(negedge clk);
            waited++;
         end
      end
      check("abort.reach_pulse2", (seen == 2), 1'b1);
      #1 rst = 1'b0;
      #1;
      check("abort.out_async",  bus.out,  1'b0);
      check("abort.busy_async", bus.busy, 1'b0);
      check("abort.done_async", bus.done, 1'b0);
      check("abort.mod3_async", bus.mod3, 1'b1);
      @(negedge clk);
      check("abort.no_done", bus.done, 1'b0);
      check("abort.out_low", bus.out,  1'b0);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         push_exp($sformatf("post_abort[%0d]", i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      drain(-10, 0, 0);

      start_train(1, 0);
      push_train(1, 0, "c1");
      drain(-10, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Moore-style transmitter that produces serial pulse trains on `out`: N single-cycle high pulses, each followed by a programmable low gap.
- It is the stimulus source for the team's mod-3 pulse-counting detector FSMs.
- It also drives `mod3`, a registered copy of the output a mod-3 detector should show after the pulses sent so far. Benches compare the detector's output against it.
- Sits between the lab test controller (start/count/gap) and the detector's serial input.

Parameters:
- CNT_W, 8, width of the pulse-count request and of the internal sent counter.
- GAP_W, 4, width of the gap-length request (low cycles between pulses).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low. rst=0 forces the reset state immediately, independent of clk.
- start  input  1  request; sampled only in IDLE.
- count  input  CNT_W  number of pulses to emit; latched when start is accepted.
- gap  input  GAP_W  low cycles after each non-final pulse; latched with count.
- out  output  1  serial pulse stream.
- busy  output  1  high in PULSE and GAP states.
- done  output  1  one-cycle completion strobe.
- mod3  output  1  high when pulses sent so far ≡ 0 (mod 3).

Behaviour:
- All outputs are registered Moore outputs, decoded from state and counters only. No combinational path from inputs to outputs.
- Reset (rst=0, async): state=IDLE, out=0, busy=0, done=0, sent=0, residue=0, mod3=1, latched count/gap=0.
- States: IDLE, PULSE, GAP, DONE (2-bit encoding).
- IDLE:
  - start=1 and count≠0: latch count/gap, clear sent and residue, go to PULSE at the next edge.
  - start=1 and count=0: go to DONE directly; no pulse is emitted.
- PULSE:
  - out=1 for exactly one cycle.
  - On exit: sent increments; residue advances 0→1→2→0 (explicit wrap, no % operator).
  - If sent+1 = latched count, go to DONE; otherwise go to GAP with gap counter loaded.
- GAP:
  - out=0 for max(gap,1) cycles, then PULSE. gap=0 is treated as 1, so pulses never merge.
- DONE: done=1, busy=0, out=0 for one cycle, then IDLE.
- mod3 = (residue==0). It updates on the same edge that ends each pulse, so it is valid in the cycle after each pulse.
- residue and mod3 hold their final values in DONE and IDLE until the next accepted start, which clears them to residue=0, mod3=1.
- start is ignored in PULSE, GAP and DONE. count/gap changes after acceptance have no effect.
- Wrap-around: count = 2^CNT_W−1 is legal. The sent counter never overflows because completion is checked before increment.
- Reset mid-train: immediate abort. out drops asynchronously, no done strobe; the next train needs a new start.
- Latency: start sampled at edge E0 → out=1 during E1–E2 → first gap begins at E2.

Test Plan:
- Reset: assert rst=0 with clk running → out=0, busy=0, done=0, mod3=1. Release, idle 5 cycles → outputs unchanged.
- count=3, gap=2, start pulsed at E0 → out by cycle E1..E8 = 1,0,0,1,0,0,1,0; done=1 only in cycle E8; busy=1 in E1..E7; mod3 reads 0,0,0,0,0,0,1 after E2..E8.
- count=0 start → done=1 one cycle after start, out never high, busy never high.
- count=4, gap=0 → out = 1,0,1,0,1,0,1 (gap forced to 1); final mod3=0 (4 mod 3=1).
- start re-asserted and count/gap changed mid-train (count=5, gap=1) → original train completes unchanged (5 pulses, 1-cycle gaps); extra start ignored.
- rst=0 asserted between clock edges during second pulse of count=6 → out falls immediately, no done; after release, new start count=1 → single pulse, done, mod3=0.
